spi_cmdparse_multi: RTL and testbench
=====================================

// Module: spi_cmdparse_multi
// PURPOSE
// - Parametrised flash/passthrough command parser for spi_device: matches the opcode byte against
//   NumSlots SW-programmed slots, then tracks address, dummy and payload phases byte by byte.
// - Sits between spi_s2p and the datapath mux; drives sel_dp_o, phase_o and captured address so
//   downstream blocks no longer count bytes themselves.
// PARAMETERS
// - NumSlots  24  number of command info slots (1..32)
// - DpW       4   width of datapath select code; code 0 = none
// - DummyW    3   width of per-slot dummy byte count (0..2**DummyW-1)
// - SlotIdxW  $clog2(NumSlots)  derived, do not override
// PORTS
// - clk_i           in   1                SPI-domain clock
// - rst_i           in   1                synchronous, active-high reset
// - module_active_i in   1                1 = flash or passthrough mode; 0 freezes FSM, outputs hold
// - cs_deassert_i   in   1                end-of-transaction; returns FSM to StIdle next cycle
// - data_valid_i    in   1                data_i holds a complete byte this cycle
// - data_i          in   8                received byte from spi_s2p
// - slot_en_i       in   NumSlots         slot valid
// - slot_opcode_i   in   NumSlots*8       per-slot opcode
// - slot_addr_en_i  in   NumSlots         slot has address phase
// - slot_addr4b_i   in   NumSlots         1 = 4-byte address, 0 = 3-byte
// - slot_dummy_i    in   NumSlots*DummyW  dummy bytes after address
// - slot_dp_i       in   NumSlots*DpW     datapath code for the slot
// - upload_mask_i   in   256              per-opcode upload enable for unmatched opcodes
// - dp_upload_i     in   DpW              datapath code used for upload
// - sel_dp_o        out  DpW              selected datapath
// - opcode_o        out  8                latched opcode
// - slot_hit_o      out  1                opcode matched an enabled slot
// - slot_idx_o      out  SlotIdxW         matched slot index
// - phase_o         out  3                0 idle,1 addr,2 dummy,3 payload,4 upload,5 ignore
// - addr_o          out  32               captured address, zero-extended for 3-byte
// - addr_done_o     out  1                one-cycle pulse: last address byte captured
// BEHAVIOUR
// - Reset: FSM StIdle; all outputs 0; counters 0.
// - Match: combinational over enabled slots; lowest matching index wins (priority, not onehot).
// - StIdle + data_valid_i: latch opcode_o, slot_idx_o, slot_hit_o, slot params (registered copy;
//   later slot CSR changes ignored until StIdle). Next state: hit&addr_en -> StAddr; hit&!addr_en
//   &dummy>0 -> StDummy; hit otherwise -> StPayload; miss&upload_mask_i[data_i] -> StUpload;
//   miss otherwise -> StIgnore (never re-parses later bytes as opcodes).
// - sel_dp_o: in StIdle, combinationally = dp_upload_i when data_valid_i & miss & upload mask
//   (opcode-only commands); else 0. Otherwise registered slot dp; StUpload -> dp_upload_i;
//   StIgnore -> 0.
// - StAddr: byte counter counts up per data_valid_i; addr shifted in MSB first; after 3 (or 4)
//   bytes -> addr_done_o pulse same cycle as transition to StDummy (dummy>0) or StPayload.
// - StDummy: counts data_valid_i bytes; after dummy count -> StPayload. StPayload/StUpload/
//   StIgnore are terminal until cs_deassert_i.
// - cs_deassert_i has priority over data_valid_i in same cycle: next state StIdle, counters 0,
//   addr_done_o not asserted; opcode_o/slot_idx_o/addr_o hold last value.
// - module_active_i = 0: no state/counter update, data_valid_i ignored; rst_i still applies.
// - rst_i mid-command: immediate return to reset values next edge.
// CONFIGURATION
// - SPI_CMDPARSE_ADDR_CAPTURE_EN defined: addr_o/addr_done_o as above.
// - Not defined: addr_o tied 0, addr_done_o tied 0, no address register; StAddr still counts
//   bytes so phase sequencing is unchanged.
// TESTING
// - Slot0 opcode 0x05 no addr/dummy, dp=1; send 0x05 -> phase 3, sel_dp_o=1, slot_idx_o=0.
// - Slot3 0x0B addr_en 3B dummy=1 dp=4; send 0B,12,34,56,FF,AA -> addr_o=0x123456 with
//   addr_done_o on byte 4, phase 2 after byte 4, phase 3 after byte 5.
// - Slots 2 and 7 both 0x03 enabled -> slot_idx_o=2; disable slot 2 -> slot_idx_o=7.
// - Miss 0xC7 with upload_mask_i[0xC7]=1 -> sel_dp_o=dp_upload_i in the data_valid_i cycle,
//   phase 4; mask 0 -> phase 5, later byte 0x05 does not match.
// - 4B slot: send opcode + 2 addr bytes then cs_deassert_i with data_valid_i -> StIdle,
//   no addr_done_o; next 0x05 parses normally.
// - module_active_i=0 during StAddr: bytes ignored, counter holds; re-enable resumes count.

Source files
------------

// File: rtl/spi_cmdparse_multi_if.sv
// Byte stream from spi_s2p into the command parser, plus the parse results
// consumed by the datapath mux.
interface spi_cmdparse_multi_if #(
   parameter int NumSlots = 24,
   parameter int DpW      = 4
);
   localparam int SlotIdxW = (NumSlots > 1) ? $clog2(NumSlots) : 1;

   logic                module_active;
   logic                cs_deassert;
   logic                data_valid;
   logic [7:0]          data;
   logic [DpW-1:0]      sel_dp;
   logic [7:0]          opcode;
   logic                slot_hit;
   logic [SlotIdxW-1:0] slot_idx;
   logic [2:0]          phase;
   logic [31:0]         addr;
   logic                addr_done;

   modport master (
      output module_active, cs_deassert, data_valid, data,
      input  sel_dp, opcode, slot_hit, slot_idx, phase, addr, addr_done
   );

   modport slave (
      input  module_active, cs_deassert, data_valid, data,
      output sel_dp, opcode, slot_hit, slot_idx, phase, addr, addr_done
   );
endinterface

// File: rtl/spi_cmdparse_multi.sv
// Flash/passthrough opcode matcher and address/dummy/payload phase tracker.
// Address capture is built only when SPI_CMDPARSE_ADDR_CAPTURE_EN is defined.
module spi_cmdparse_multi #(
   parameter int NumSlots = 24,
   parameter int DpW      = 4,
   parameter int DummyW   = 3
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NumSlots-1:0]        slot_en_i,
   input  logic [NumSlots*8-1:0]      slot_opcode_i,
   input  logic [NumSlots-1:0]        slot_addr_en_i,
   input  logic [NumSlots-1:0]        slot_addr4b_i,
   input  logic [NumSlots*DummyW-1:0] slot_dummy_i,
   input  logic [NumSlots*DpW-1:0]    slot_dp_i,
   input  logic [255:0]               upload_mask_i,
   input  logic [DpW-1:0]             dp_upload_i,
   spi_cmdparse_multi_if.slave        bus
);
   localparam int SlotIdxW = (NumSlots > 1) ? $clog2(NumSlots) : 1;
   localparam int CntW     = (DummyW > 2) ? DummyW : 2;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StAddr    = 3'd1,
      StDummy   = 3'd2,
      StPayload = 3'd3,
      StUpload  = 3'd4,
      StIgnore  = 3'd5
   } state_e;

   state_e              state_r;
   logic [CntW-1:0]     cnt_r;
   logic [7:0]          opcode_r;
   logic                slot_hit_r;
   logic [SlotIdxW-1:0] slot_idx_r;
   logic                addr4b_r;
   logic [DummyW-1:0]   dummy_r;
   logic [DpW-1:0]      sel_dp_r;

   logic                match_hit_s;
   logic [SlotIdxW-1:0] match_idx_s;
   logic                sel_addr_en_s;
   logic                sel_addr4b_s;
   logic [DummyW-1:0]   sel_dummy_s;
   logic [DpW-1:0]      sel_dp_slot_s;
   logic                upload_hit_s;
   logic [CntW-1:0]     addr_last_s;
   logic [CntW-1:0]     dummy_last_s;
   logic [DpW-1:0]      sel_dp_s;
   logic                byte_take_s;

   // Priority match: scan downwards so the lowest enabled matching slot wins
   always_comb begin
      match_hit_s = 1'b0;
      match_idx_s = '0;
      for (int i = NumSlots - 1; i >= 0; i--) begin
         if (slot_en_i[i] && (slot_opcode_i[i*8 +: 8] == bus.data)) begin
            match_hit_s = 1'b1;
            match_idx_s = SlotIdxW'(i);
         end else begin
            match_hit_s = match_hit_s;
         end
      end
   end

   assign sel_addr_en_s = slot_addr_en_i[match_idx_s];
   assign sel_addr4b_s  = slot_addr4b_i[match_idx_s];
   assign sel_dummy_s   = slot_dummy_i[int'(match_idx_s)*DummyW +: DummyW];
   assign sel_dp_slot_s = slot_dp_i[int'(match_idx_s)*DpW +: DpW];

   assign upload_hit_s = bus.module_active & bus.data_valid & ~match_hit_s
                         & upload_mask_i[bus.data];
   assign addr_last_s  = addr4b_r ? CntW'(3) : CntW'(2);
   assign dummy_last_s = CntW'(dummy_r) - CntW'(1);
   assign byte_take_s  = bus.module_active & ~bus.cs_deassert & bus.data_valid;

   // Datapath select: opcode-only upload must be visible in the opcode cycle itself
   always_comb begin
      if (state_r == StIdle) begin
         sel_dp_s = upload_hit_s ? dp_upload_i : {DpW{1'b0}};
      end else if (state_r == StUpload) begin
         sel_dp_s = dp_upload_i;
      end else begin
         sel_dp_s = sel_dp_r;
      end
   end

   // Command FSM with latched opcode, slot index and slot parameters
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r    <= StIdle;
         cnt_r      <= '0;
         opcode_r   <= 8'h00;
         slot_hit_r <= 1'b0;
         slot_idx_r <= '0;
         addr4b_r   <= 1'b0;
         dummy_r    <= '0;
         sel_dp_r   <= '0;
      end else if (!bus.module_active) begin
         state_r <= state_r;
      end else if (bus.cs_deassert) begin
         state_r <= StIdle;
         cnt_r   <= '0;
      end else if (bus.data_valid) begin
         case (state_r)
            StIdle: begin
               opcode_r   <= bus.data;
               slot_hit_r <= match_hit_s;
               slot_idx_r <= match_idx_s;
               addr4b_r   <= sel_addr4b_s;
               dummy_r    <= sel_dummy_s;
               sel_dp_r   <= match_hit_s ? sel_dp_slot_s : {DpW{1'b0}};
               cnt_r      <= '0;
               if (match_hit_s && sel_addr_en_s) begin
                  state_r <= StAddr;
               end else if (match_hit_s && (sel_dummy_s != '0)) begin
                  state_r <= StDummy;
               end else if (match_hit_s) begin
                  state_r <= StPayload;
               end else if (upload_mask_i[bus.data]) begin
                  state_r <= StUpload;
               end else begin
                  state_r <= StIgnore;
               end
            end
            StAddr: begin
               if (cnt_r == addr_last_s) begin
                  cnt_r   <= '0;
                  state_r <= (dummy_r != '0) ? StDummy : StPayload;
               end else begin
                  cnt_r <= cnt_r + CntW'(1);
               end
            end
            StDummy: begin
               if (cnt_r == dummy_last_s) begin
                  cnt_r   <= '0;
                  state_r <= StPayload;
               end else begin
                  cnt_r <= cnt_r + CntW'(1);
               end
            end
            default: begin
               state_r <= state_r;
            end
         endcase
      end else begin
         state_r <= state_r;
      end
   end

   assign bus.sel_dp   = sel_dp_s;
   assign bus.opcode   = opcode_r;
   assign bus.slot_hit = slot_hit_r;
   assign bus.slot_idx = slot_idx_r;
   assign bus.phase    = state_r;

`ifdef SPI_CMDPARSE_ADDR_CAPTURE_EN
   logic [23:0] addr_sh_r;
   logic [31:0] addr_r;
   logic        addr_done_r;

   // Address is published only once complete, so it holds across aborted commands
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_sh_r   <= 24'h000000;
         addr_r      <= 32'h00000000;
         addr_done_r <= 1'b0;
      end else if (byte_take_s && (state_r == StAddr)) begin
         addr_sh_r <= {addr_sh_r[15:0], bus.data};
         if (cnt_r == addr_last_s) begin
            addr_r      <= addr4b_r ? {addr_sh_r, bus.data}
                                    : {8'h00, addr_sh_r[15:0], bus.data};
            addr_done_r <= 1'b1;
         end else begin
            addr_done_r <= 1'b0;
         end
      end else begin
         addr_done_r <= 1'b0;
      end
   end

   assign bus.addr      = addr_r;
   assign bus.addr_done = addr_done_r;
`else
   assign bus.addr      = 32'h00000000;
   assign bus.addr_done = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmdparse_multi.sv
// Randomised bench for spi_cmdparse_multi against a transaction-level model that
// derives the phase from the byte count since the opcode.
module tb_spi_cmdparse_multi;
   localparam int NumSlots = 24;
   localparam int DpW      = 4;
   localparam int DummyW   = 3;
`ifdef SPI_CMDPARSE_ADDR_CAPTURE_EN
   localparam bit AddrCap = 1'b1;
`else
   localparam bit AddrCap = 1'b0;
`endif

   logic                       clk_i = 1'b0;
   logic                       rst_i;
   logic [NumSlots-1:0]        slot_en_i;
   logic [NumSlots*8-1:0]      slot_opcode_i;
   logic [NumSlots-1:0]        slot_addr_en_i;
   logic [NumSlots-1:0]        slot_addr4b_i;
   logic [NumSlots*DummyW-1:0] slot_dummy_i;
   logic [NumSlots*DpW-1:0]    slot_dp_i;
   logic [255:0]               upload_mask_i;
   logic [DpW-1:0]             dp_upload_i;

   spi_cmdparse_multi_if #(.NumSlots(NumSlots), .DpW(DpW)) bus ();

   spi_cmdparse_multi #(.NumSlots(NumSlots), .DpW(DpW), .DummyW(DummyW)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .slot_en_i      (slot_en_i),
      .slot_opcode_i  (slot_opcode_i),
      .slot_addr_en_i (slot_addr_en_i),
      .slot_addr4b_i  (slot_addr4b_i),
      .slot_dummy_i   (slot_dummy_i),
      .slot_dp_i      (slot_dp_i),
      .upload_mask_i  (upload_mask_i),
      .dp_upload_i    (dp_upload_i),
      .bus            (bus)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   // Transaction model: busy flag, bytes after opcode, snapshot of the matched slot
   bit          m_busy;
   bit          m_hit;
   bit          m_upl;
   bit          m_aen;
   bit          m_a4;
   int          m_idx;
   int          m_dummy;
   int          m_k;
   logic [7:0]  m_op;
   logic [3:0]  m_dp;
   logic [31:0] m_acc;
   logic [31:0] m_addr;
   bit          m_done;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_slot(input int idx, input bit en, input logic [7:0] op, input bit aen,
                           input bit a4, input int dummy, input int dp);
      slot_en_i[idx]                  = en;
      slot_opcode_i[idx*8 +: 8]       = op;
      slot_addr_en_i[idx]             = aen;
      slot_addr4b_i[idx]              = a4;
      slot_dummy_i[idx*DummyW +: DummyW] = DummyW'(dummy);
      slot_dp_i[idx*DpW +: DpW]       = DpW'(dp);
   endtask

   function automatic void find_slot(input logic [7:0] d, output bit hit, output int idx);
      hit = 1'b0;
      idx = 0;
      for (int i = 0; i < NumSlots; i++) begin
         if (!hit && slot_en_i[i] && (slot_opcode_i[i*8 +: 8] == d)) begin
            hit = 1'b1;
            idx = i;
         end
      end
   endfunction

   function automatic int addr_len_f();
      if (m_hit && m_aen) return m_a4 ? 4 : 3;
      return 0;
   endfunction

   function automatic logic [31:0] exp_phase_f();
      if (!m_busy) return 32'd0;
      if (!m_hit) return m_upl ? 32'd4 : 32'd5;
      if (m_k < addr_len_f()) return 32'd1;
      if (m_k < addr_len_f() + m_dummy) return 32'd2;
      return 32'd3;
   endfunction

   function automatic logic [31:0] exp_sel_f();
      bit h;
      int ix;
      if (!m_busy) begin
         find_slot(bus.data, h, ix);
         if (bus.module_active && bus.data_valid && !h && upload_mask_i[bus.data])
            return 32'(dp_upload_i);
         return 32'd0;
      end
      case (exp_phase_f())
         32'd1, 32'd2, 32'd3: return 32'(m_dp);
         32'd4:               return 32'(dp_upload_i);
         default:             return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_busy = 1'b0; m_hit = 1'b0; m_upl = 1'b0; m_aen = 1'b0; m_a4 = 1'b0;
      m_idx = 0; m_dummy = 0; m_k = 0; m_op = 8'h00; m_dp = 4'h0;
      m_acc = 32'h0; m_addr = 32'h0; m_done = 1'b0;
   endtask

   task automatic model_step();
      m_done = 1'b0;
      if (rst_i) begin
         model_reset();
      end else if (!bus.module_active) begin
         m_done = 1'b0;
      end else if (bus.cs_deassert) begin
         m_busy = 1'b0;
      end else if (bus.data_valid) begin
         if (!m_busy) begin
            m_busy = 1'b1;
            m_k    = 0;
            m_acc  = 32'h0;
            m_op   = bus.data;
            find_slot(bus.data, m_hit, m_idx);
            m_aen   = m_hit && slot_addr_en_i[m_idx];
            m_a4    = slot_addr4b_i[m_idx];
            m_dummy = m_hit ? int'(slot_dummy_i[m_idx*DummyW +: DummyW]) : 0;
            m_dp    = m_hit ? slot_dp_i[m_idx*DpW +: DpW] : 4'h0;
            m_upl   = !m_hit && upload_mask_i[bus.data];
         end else if (m_hit) begin
            if (m_k < addr_len_f()) begin
               m_acc = {m_acc[23:0], bus.data};
               m_k++;
               if (m_k == addr_len_f()) begin
                  m_done = 1'b1;
                  m_addr = m_acc;
               end
            end else if (m_k < addr_len_f() + m_dummy) begin
               m_k++;
            end
         end
      end
   endtask

   task automatic check_outputs();
      check_val("phase",     32'(bus.phase),     exp_phase_f());
      check_val("opcode",    32'(bus.opcode),    32'(m_op));
      check_val("slot_hit",  32'(bus.slot_hit),  32'(m_hit));
      check_val("slot_idx",  32'(bus.slot_idx),  32'(m_idx));
      check_val("addr",      bus.addr,           AddrCap ? m_addr : 32'h0);
      check_val("addr_done", 32'(bus.addr_done), AddrCap ? 32'(m_done) : 32'h0);
   endtask

   task automatic cycle(input bit act, input bit cs, input bit dv, input logic [7:0] d);
      @(negedge clk_i);
      bus.module_active = act;
      bus.cs_deassert   = cs;
      bus.data_valid    = dv;
      bus.data          = d;
      #1;
      check_val("sel_dp", 32'(bus.sel_dp), exp_sel_f());
      @(posedge clk_i);
      model_step();
      #1;
      check_outputs();
   endtask

   task automatic send(input logic [7:0] d);
      cycle(1'b1, 1'b0, 1'b1, d);
   endtask

   task automatic end_cs();
      cycle(1'b1, 1'b1, 1'b0, 8'h00);
   endtask

   initial begin
      rst_i = 1'b1;
      bus.module_active = 1'b0; bus.cs_deassert = 1'b0;
      bus.data_valid = 1'b0;    bus.data = 8'h00;
      slot_en_i = '0; slot_opcode_i = '0; slot_addr_en_i = '0; slot_addr4b_i = '0;
      slot_dummy_i = '0; slot_dp_i = '0; upload_mask_i = '0; dp_upload_i = 4'hA;
      model_reset();
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      cycle(1'b1, 1'b0, 1'b1, 8'h05);
      check_val("rst_phase", 32'(bus.phase), 32'd0);
      check_val("rst_sel", 32'(bus.sel_dp), 32'd0);
      rst_i = 1'b0;

      set_slot(0, 1'b1, 8'h05, 1'b0, 1'b0, 0, 1);
      set_slot(3, 1'b1, 8'h0B, 1'b1, 1'b0, 1, 4);
      set_slot(2, 1'b1, 8'h03, 1'b1, 1'b0, 0, 2);
      set_slot(7, 1'b1, 8'h03, 1'b0, 1'b0, 2, 7);
      set_slot(5, 1'b1, 8'h6B, 1'b1, 1'b1, 0, 3);

      // Opcode-only read status
      send(8'h05);
      check_val("t1_phase", 32'(bus.phase), 32'd3);
      check_val("t1_sel", 32'(bus.sel_dp), 32'd1);
      check_val("t1_idx", 32'(bus.slot_idx), 32'd0);
      end_cs();

      // 3-byte address plus one dummy byte
      send(8'h0B); send(8'h12); send(8'h34); send(8'h56);
      check_val("t2_addr", bus.addr, AddrCap ? 32'h00123456 : 32'h0);
      check_val("t2_done", 32'(bus.addr_done), AddrCap ? 32'd1 : 32'd0);
      check_val("t2_phase4", 32'(bus.phase), 32'd2);
      send(8'hFF);
      check_val("t2_phase5", 32'(bus.phase), 32'd3);
      check_val("t2_done5", 32'(bus.addr_done), 32'd0);
      send(8'hAA);
      end_cs();

      // Priority between duplicate opcodes
      send(8'h03);
      check_val("t3_idx2", 32'(bus.slot_idx), 32'd2);
      end_cs();
      slot_en_i[2] = 1'b0;
      send(8'h03);
      check_val("t3_idx7", 32'(bus.slot_idx), 32'd7);
      check_val("t3_phase", 32'(bus.phase), 32'd2);
      end_cs();
      slot_en_i[2] = 1'b1;

      // Unmatched opcode with and without upload
      upload_mask_i[8'hC7] = 1'b1;
      send(8'hC7);
      check_val("t4_phase_up", 32'(bus.phase), 32'd4);
      end_cs();
      upload_mask_i[8'hC7] = 1'b0;
      send(8'hC7);
      send(8'h05);
      check_val("t4_phase_ign", 32'(bus.phase), 32'd5);
      check_val("t4_hit", 32'(bus.slot_hit), 32'd0);
      end_cs();

      // 4-byte address aborted by CS with a simultaneous byte
      send(8'h6B); send(8'h01); send(8'h02);
      cycle(1'b1, 1'b1, 1'b1, 8'h03);
      check_val("t5_phase", 32'(bus.phase), 32'd0);
      check_val("t5_done", 32'(bus.addr_done), 32'd0);
      send(8'h05);
      check_val("t5_next", 32'(bus.phase), 32'd3);
      end_cs();

      // Freeze while inactive during the address phase
      send(8'h0B);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 8'h99);
      check_val("t6_frozen", 32'(bus.phase), 32'd1);
      send(8'h12); send(8'h34); send(8'h56);
      check_val("t6_phase", 32'(bus.phase), 32'd2);
      check_val("t6_addr", bus.addr, AddrCap ? 32'h00123456 : 32'h0);
      end_cs();

      // Random traffic with periodic slot reconfiguration mid-command
      for (int c = 0; c < 1500; c++) begin
         if (c % 100 == 0) begin
            for (int s = 0; s < NumSlots; s++)
               set_slot(s, ($urandom_range(0, 1) == 1), 8'($urandom_range(0, 15)),
                        ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                        int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
            for (int w = 0; w < 8; w++) upload_mask_i[w*32 +: 32] = $urandom;
            dp_upload_i = 4'($urandom_range(0, 15));
         end
         rst_i = ($urandom_range(0, 299) == 0);
         cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 11) == 0),
               ($urandom_range(0, 2) != 0),
               ($urandom_range(0, 9) < 7) ? 8'($urandom_range(0, 15)) : 8'($urandom));
      end
      rst_i = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
